// File: rtl/hazard_dest_tracker.sv
// ----------------------------------------------------------------------------
// hazard_dest_tracker
//
// Producer side of the load-use / JALR hazard check. It records the
// destination register, rt and memRead of each decoded instruction and shifts
// them through the ID/EX, EX/MEM and MEM/WB slots. Hazard detection compares
// those slots against IF/ID and returns a stall request, which this block uses
// to insert bubbles. The block also counts stall and flush cycles, and it
// raises a sticky error when a stall never releases.
//
// Parameters
//   CNT_W      width of the stall/flush counters, which saturate at 2^CNT_W-1
//   MAX_STALL  consecutive stall cycles allowed before o_stall_err (1..255)
//
// Ports
//   i_clk                 core clock; all state updates on the rising edge
//   i_rst                 synchronous, active-high reset
//   i_stall               bubble request from hazard detection
//   i_flush               squash the instruction leaving ID
//   i_id_valid            IF/ID holds a real instruction
//   i_id_regWrite         decoded instruction writes the register file
//   i_id_memRead          decoded instruction is a load
//   i_id_writereg[2:0]    decoded destination register
//   i_id_rt[2:0]          decoded rt field
//   o_idex_*              ID/EX slot: valid, regWrite, memRead, writereg, rt
//   o_exmem_*             EX/MEM slot: valid, regWrite, writereg
//   o_memwb_*             MEM/WB slot: valid, regWrite, writereg
//   o_stall_count         saturating count of stall cycles
//   o_flush_count         saturating count of flush cycles
//   o_stall_err           sticky; stall held longer than MAX_STALL cycles
//
// Every output comes straight from a register, so there is no combinational
// path from input to output.
// ----------------------------------------------------------------------------
module hazard_dest_tracker #(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned MAX_STALL = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_stall,
   input  logic             i_flush,
   input  logic             i_id_valid,
   input  logic             i_id_regWrite,
   input  logic             i_id_memRead,
   input  logic [2:0]       i_id_writereg,
   input  logic [2:0]       i_id_rt,
   output logic             o_idex_valid,
   output logic             o_idex_regWrite,
   output logic             o_idex_memRead,
   output logic [2:0]       o_idex_writereg,
   output logic [2:0]       o_idex_rt,
   output logic             o_exmem_valid,
   output logic             o_exmem_regWrite,
   output logic [2:0]       o_exmem_writereg,
   output logic             o_memwb_valid,
   output logic             o_memwb_regWrite,
   output logic [2:0]       o_memwb_writereg,
   output logic [CNT_W-1:0] o_stall_count,
   output logic [CNT_W-1:0] o_flush_count,
   output logic             o_stall_err
);

   localparam logic [CNT_W-1:0] CntMax    = '1;
   localparam logic [7:0]       RunMax    = 8'hff;
   localparam logic [7:0]       MaxStallC = 8'(MAX_STALL);

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   logic             r_idex_valid;
   logic             r_idex_regWrite;
   logic             r_idex_memRead;
   logic [2:0]       r_idex_writereg;
   logic [2:0]       r_idex_rt;
   logic             r_exmem_valid;
   logic             r_exmem_regWrite;
   logic [2:0]       r_exmem_writereg;
   logic             r_memwb_valid;
   logic             r_memwb_regWrite;
   logic [2:0]       r_memwb_writereg;
   logic [CNT_W-1:0] r_stall_count;
   logic [CNT_W-1:0] r_flush_count;
   logic [7:0]       r_stall_run;
   logic             r_stall_err;

   // ---------------------------------------------------------------------
   // Next-state values
   // ---------------------------------------------------------------------
   logic             w_bubble;
   logic             w_idex_valid;
   logic             w_idex_regWrite;
   logic             w_idex_memRead;
   logic [2:0]       w_idex_writereg;
   logic [2:0]       w_idex_rt;
   logic [CNT_W-1:0] w_stall_count;
   logic [CNT_W-1:0] w_flush_count;
   logic [7:0]       w_stall_run;
   logic             w_stall_err;

   // ID/EX capture. A bubble clears every field, including writereg and rt.
   // Consumers still qualify writereg with valid/regWrite, because r0 is a
   // real register.
   always_comb begin
      w_bubble        = i_stall | i_flush | ~i_id_valid;
      w_idex_valid    = 1'b0;
      w_idex_regWrite = 1'b0;
      w_idex_memRead  = 1'b0;
      w_idex_writereg = 3'b000;
      w_idex_rt       = 3'b000;
      if (!w_bubble) begin
         w_idex_valid    = 1'b1;
         w_idex_regWrite = i_id_regWrite;
         w_idex_memRead  = i_id_memRead;
         w_idex_writereg = i_id_writereg;
         w_idex_rt       = i_id_rt;
      end
   end

   // Activity counters; they hold at all-ones instead of wrapping.
   always_comb begin
      w_stall_count = r_stall_count;
      w_flush_count = r_flush_count;
      if (i_stall && (r_stall_count != CntMax)) begin
         w_stall_count = r_stall_count + CNT_W'(1);
      end
      if (i_flush && (r_flush_count != CntMax)) begin
         w_flush_count = r_flush_count + CNT_W'(1);
      end
   end

   // Stall watchdog. The error fires on the cycle the run reaches
   // MAX_STALL+1, which is the cycle a stall arrives while the run already
   // equals MAX_STALL. Because the run saturates, the compare stays valid even
   // for MAX_STALL = 255.
   always_comb begin
      w_stall_run = 8'h00;
      w_stall_err = r_stall_err;
      if (i_stall) begin
         w_stall_run = (r_stall_run == RunMax) ? RunMax : r_stall_run + 8'h01;
         if (r_stall_run >= MaxStallC) begin
            w_stall_err = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Registers. Reset takes priority over every other input.
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_idex_valid     <= 1'b0;
         r_idex_regWrite  <= 1'b0;
         r_idex_memRead   <= 1'b0;
         r_idex_writereg  <= 3'b000;
         r_idex_rt        <= 3'b000;
         r_exmem_valid    <= 1'b0;
         r_exmem_regWrite <= 1'b0;
         r_exmem_writereg <= 3'b000;
         r_memwb_valid    <= 1'b0;
         r_memwb_regWrite <= 1'b0;
         r_memwb_writereg <= 3'b000;
         r_stall_count    <= '0;
         r_flush_count    <= '0;
         r_stall_run      <= 8'h00;
         r_stall_err      <= 1'b0;
      end else begin
         r_idex_valid     <= w_idex_valid;
         r_idex_regWrite  <= w_idex_regWrite;
         r_idex_memRead   <= w_idex_memRead;
         r_idex_writereg  <= w_idex_writereg;
         r_idex_rt        <= w_idex_rt;
         // The later slots have no back-pressure and advance every cycle.
         r_exmem_valid    <= r_idex_valid;
         r_exmem_regWrite <= r_idex_regWrite;
         r_exmem_writereg <= r_idex_writereg;
         r_memwb_valid    <= r_exmem_valid;
         r_memwb_regWrite <= r_exmem_regWrite;
         r_memwb_writereg <= r_exmem_writereg;
         r_stall_count    <= w_stall_count;
         r_flush_count    <= w_flush_count;
         r_stall_run      <= w_stall_run;
         r_stall_err      <= w_stall_err;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign o_idex_valid     = r_idex_valid;
   assign o_idex_regWrite  = r_idex_regWrite;
   assign o_idex_memRead   = r_idex_memRead;
   assign o_idex_writereg  = r_idex_writereg;
   assign o_idex_rt        = r_idex_rt;
   assign o_exmem_valid    = r_exmem_valid;
   assign o_exmem_regWrite = r_exmem_regWrite;
   assign o_exmem_writereg = r_exmem_writereg;
   assign o_memwb_valid    = r_memwb_valid;
   assign o_memwb_regWrite = r_memwb_regWrite;
   assign o_memwb_writereg = r_memwb_writereg;
   assign o_stall_count    = r_stall_count;
   assign o_flush_count    = r_flush_count;
   assign o_stall_err      = r_stall_err;

endmodule

// File: tb/tb_hazard_dest_tracker.sv
// ----------------------------------------------------------------------------
// tb_hazard_dest_tracker
//
// Drives two instances with the same inputs:
//   dut     uses the default parameters (CNT_W=16, MAX_STALL=4)
//   dut_w4  uses CNT_W=4 and MAX_STALL=2, to reach counter saturation quickly
//
// For every driven cycle the expected ID/EX entry is queued. That entry is
// popped one cycle later as the expected EX/MEM entry, and popped one cycle
// after that as the expected MEM/WB entry.
// ----------------------------------------------------------------------------
module tb_hazard_dest_tracker;

   typedef struct packed {
      logic       v;
      logic       rw;
      logic       mr;
      logic [2:0] wr;
      logic [2:0] rt;
   } slot_t;

   logic        clk = 1'b0;
   logic        rst, stall, flush, id_valid, id_regWrite, id_memRead;
   logic [2:0]  id_writereg, id_rt;

   logic        idex_valid, idex_regWrite, idex_memRead;
   logic [2:0]  idex_writereg, idex_rt;
   logic        exmem_valid, exmem_regWrite;
   logic [2:0]  exmem_writereg;
   logic        memwb_valid, memwb_regWrite;
   logic [2:0]  memwb_writereg;
   logic [15:0] stall_count, flush_count;
   logic        stall_err;

   logic        w4_idex_valid, w4_idex_regWrite, w4_idex_memRead;
   logic [2:0]  w4_idex_writereg, w4_idex_rt;
   logic        w4_exmem_valid, w4_exmem_regWrite;
   logic [2:0]  w4_exmem_writereg;
   logic        w4_memwb_valid, w4_memwb_regWrite;
   logic [2:0]  w4_memwb_writereg;
   logic [3:0]  w4_stall_count, w4_flush_count;
   logic        w4_stall_err;

   int          n_chk  = 0;
   int          n_fail = 0;

   slot_t       q_ex[$];
   slot_t       q_wb[$];
   int          m_sc16, m_fc16, m_sc4, m_fc4, m_run16, m_run4;
   logic        m_err16, m_err4;

   always #5 clk = ~clk;

   hazard_dest_tracker dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_stall          (stall),
      .i_flush          (flush),
      .i_id_valid       (id_valid),
      .i_id_regWrite    (id_regWrite),
      .i_id_memRead     (id_memRead),
      .i_id_writereg    (id_writereg),
      .i_id_rt          (id_rt),
      .o_idex_valid     (idex_valid),
      .o_idex_regWrite  (idex_regWrite),
      .o_idex_memRead   (idex_memRead),
      .o_idex_writereg  (idex_writereg),
      .o_idex_rt        (idex_rt),
      .o_exmem_valid    (exmem_valid),
      .o_exmem_regWrite (exmem_regWrite),
      .o_exmem_writereg (exmem_writereg),
      .o_memwb_valid    (memwb_valid),
      .o_memwb_regWrite (memwb_regWrite),
      .o_memwb_writereg (memwb_writereg),
      .o_stall_count    (stall_count),
      .o_flush_count    (flush_count),
      .o_stall_err      (stall_err)
   );

   hazard_dest_tracker #(
      .CNT_W     (4),
      .MAX_STALL (2)
   ) dut_w4 (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_stall          (stall),
      .i_flush          (flush),
      .i_id_valid       (id_valid),
      .i_id_regWrite    (id_regWrite),
      .i_id_memRead     (id_memRead),
      .i_id_writereg    (id_writereg),
      .i_id_rt          (id_rt),
      .o_idex_valid     (w4_idex_valid),
      .o_idex_regWrite  (w4_idex_regWrite),
      .o_idex_memRead   (w4_idex_memRead),
      .o_idex_writereg  (w4_idex_writereg),
      .o_idex_rt        (w4_idex_rt),
      .o_exmem_valid    (w4_exmem_valid),
      .o_exmem_regWrite (w4_exmem_regWrite),
      .o_exmem_writereg (w4_exmem_writereg),
      .o_memwb_valid    (w4_memwb_valid),
      .o_memwb_regWrite (w4_memwb_regWrite),
      .o_memwb_writereg (w4_memwb_writereg),
      .o_stall_count    (w4_stall_count),
      .o_flush_count    (w4_flush_count),
      .o_stall_err      (w4_stall_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, update the reference model, then compare after the edge.
   task automatic step(input logic r, input logic st, input logic fl, input logic v,
                       input logic rw, input logic mr, input logic [2:0] wr,
                       input logic [2:0] rt);
      slot_t e, ex, wb;
      rst = r; stall = st; flush = fl; id_valid = v;
      id_regWrite = rw; id_memRead = mr; id_writereg = wr; id_rt = rt;
      e = '0;
      if (!r && !st && !fl && v) begin
         e.v = 1'b1; e.rw = rw; e.mr = mr; e.wr = wr; e.rt = rt;
      end
      if (r) begin
         ex = '0; wb = '0;
         q_ex.delete(); q_wb.delete();
         m_sc16 = 0; m_fc16 = 0; m_sc4 = 0; m_fc4 = 0;
         m_run16 = 0; m_run4 = 0; m_err16 = 1'b0; m_err4 = 1'b0;
      end else begin
         ex = (q_ex.size() > 0) ? q_ex.pop_front() : '0;
         wb = (q_wb.size() > 0) ? q_wb.pop_front() : '0;
         if (st && m_sc16 < 65535) m_sc16++;
         if (fl && m_fc16 < 65535) m_fc16++;
         if (st && m_sc4 < 15) m_sc4++;
         if (fl && m_fc4 < 15) m_fc4++;
         if (st) begin
            if (m_run16 + 1 > 4) m_err16 = 1'b1;
            if (m_run4 + 1 > 2) m_err4 = 1'b1;
            if (m_run16 < 255) m_run16++;
            if (m_run4 < 255) m_run4++;
         end else begin
            m_run16 = 0; m_run4 = 0;
         end
      end
      q_ex.push_back(e);
      q_wb.push_back(ex);
      @(posedge clk);
      #1;
      chk("idex_valid", 32'(idex_valid), 32'(e.v));
      chk("idex_regWrite", 32'(idex_regWrite), 32'(e.rw));
      chk("idex_memRead", 32'(idex_memRead), 32'(e.mr));
      chk("idex_writereg", 32'(idex_writereg), 32'(e.wr));
      chk("idex_rt", 32'(idex_rt), 32'(e.rt));
      chk("exmem_valid", 32'(exmem_valid), 32'(ex.v));
      chk("exmem_regWrite", 32'(exmem_regWrite), 32'(ex.rw));
      chk("exmem_writereg", 32'(exmem_writereg), 32'(ex.wr));
      chk("memwb_valid", 32'(memwb_valid), 32'(wb.v));
      chk("memwb_regWrite", 32'(memwb_regWrite), 32'(wb.rw));
      chk("memwb_writereg", 32'(memwb_writereg), 32'(wb.wr));
      chk("stall_count", 32'(stall_count), 32'(m_sc16));
      chk("flush_count", 32'(flush_count), 32'(m_fc16));
      chk("stall_err", 32'(stall_err), 32'(m_err16));
      chk("w4_idex_valid", 32'(w4_idex_valid), 32'(e.v));
      chk("w4_stall_count", 32'(w4_stall_count), 32'(m_sc4));
      chk("w4_flush_count", 32'(w4_flush_count), 32'(m_fc4));
      chk("w4_stall_err", 32'(w4_stall_err), 32'(m_err4));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
      id_regWrite = 1'b0; id_memRead = 1'b0; id_writereg = 3'd0; id_rt = 3'd0;

      // Reset, then idle: every output stays 0.
      do_reset(2);
      chk("rst_stall_count", 32'(stall_count), 32'd0);
      idle(3);

      // A single load walks through all three slots, then the valids drop.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 3'd3);
      chk("t2_idex_wr", 32'(idex_writereg), 32'd5);
      chk("t2_idex_rt", 32'(idex_rt), 32'd3);
      chk("t2_idex_mr", 32'(idex_memRead), 32'd1);
      idle(1);
      chk("t2_exmem_wr", 32'(exmem_writereg), 32'd5);
      idle(1);
      chk("t2_memwb_wr", 32'(memwb_writereg), 32'd5);
      idle(1);
      chk("t2_memwb_valid_drop", 32'(memwb_valid), 32'd0);

      // Load-use: one stall cycle, then the dependent op is captured.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 3'd1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 3'd2);
      chk("t3_bubble", 32'(idex_valid), 32'd0);
      chk("t3_stall_count", 32'(stall_count), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 3'd2);
      chk("t3_capture", 32'(idex_writereg), 32'd4);
      idle(3);

      // Flush and stall together on a valid instruction.
      do_reset(1);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 3'd7);
      chk("t4_bubble", 32'(idex_valid), 32'd0);
      chk("t4_stall_count", 32'(stall_count), 32'd1);
      chk("t4_flush_count", 32'(flush_count), 32'd1);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 3'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
      chk("t4_r0_valid", 32'(idex_valid), 32'd1);
      idle(3);

      // Watchdog: a 4-cycle stall is allowed; a 5-cycle stall sets the error.
      do_reset(1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 3'd3);
      chk("t5_no_err", 32'(stall_err), 32'd0);
      idle(2);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 3'd3);
      chk("t5_err", 32'(stall_err), 32'd1);
      idle(2);
      chk("t5_err_sticky", 32'(stall_err), 32'd1);

      // Reset in mid-stall/mid-flush clears everything on the next edge.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 3'd5);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 3'd5);
      chk("rst_mid_err", 32'(stall_err), 32'd0);
      chk("rst_mid_exmem", 32'(exmem_valid), 32'd0);
      idle(2);

      // Saturation of the narrow counter.
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
      chk("t6_w4_sat", 32'(w4_stall_count), 32'd15);
      chk("t6_w4_fsat", 32'(w4_flush_count), 32'd15);
      chk("t6_wide", 32'(stall_count), 32'd20);
      idle(2);

      // Random traffic, with an occasional reset.
      for (int i = 0; i < 200; i++) begin
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
              3'($urandom), 3'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
